// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction and forms its final result.
// It drives the register-file write port, counts retired instructions and
// halts the core after an ebreak commits.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic             in_ebreak,
  input  logic             commit_stall,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_pc;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic [XLEN-1:0]   r_result;
  logic              r_ebreak;
  logic [CNT_W-1:0]  r_instret;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_result;
  logic              w_commit;
  logic              w_accept;

  // The held entry retires whenever it is present and commit is not stalled;
  // a new instruction can slide in behind it in the same cycle unless the
  // entry is an ebreak, which must be the last thing the core retires.
  assign w_commit     = (r_state == FULL) && !commit_stall;
  assign in_ready     = (r_state == EMPTY) ||
                        ((r_state == FULL) && !commit_stall && !r_ebreak);
  assign w_accept     = in_valid && in_ready;

  assign rf_wen       = w_commit && r_wen && (r_rd != 5'd0);
  assign rf_waddr     = r_rd;
  assign rf_wdata     = r_result;
  assign commit_valid = w_commit;
  assign commit_pc    = r_pc;
  assign halted       = (r_state == HALTED);
  assign instret      = r_instret;

  // Pick the addressed byte/half lane of the memory word and extend it to XLEN.
  always_comb begin
    w_byte   = in_mem_rdata[{in_addr_lo, 3'b000} +: 8];
    w_half   = in_mem_rdata[{in_addr_lo[1], 4'b0000} +: 16];
    w_result = in_alu_result;
    if (in_is_load) begin
      case (in_funct3)
        3'b000:  w_result = {{(XLEN-8){w_byte[7]}}, w_byte};
        3'b100:  w_result = {{(XLEN-8){1'b0}}, w_byte};
        3'b001:  w_result = {{(XLEN-16){w_half[15]}}, w_half};
        3'b101:  w_result = {{(XLEN-16){1'b0}}, w_half};
        default: w_result = in_mem_rdata;
      endcase
    end
  end

  // Occupancy state machine: EMPTY/FULL track the entry, HALTED is terminal.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) r_state <= FULL;
        end
        FULL: begin
          if (w_commit) begin
            if (r_ebreak)      r_state <= HALTED;
            else if (w_accept) r_state <= FULL;
            else               r_state <= EMPTY;
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Capture the payload and precomputed result so rf_wdata comes from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= 32'd0;
      r_rd     <= 5'd0;
      r_wen    <= 1'b0;
      r_result <= '0;
      r_ebreak <= 1'b0;
    end else if (w_accept) begin
      r_pc     <= in_pc;
      r_rd     <= in_rd;
      r_wen    <= in_wen;
      r_result <= w_result;
      r_ebreak <= in_ebreak;
    end
  end

  // Retired-instruction counter, bumped once per commit and wrapping naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_commit) begin
      r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the single-issue RV32 core. It sits directly upstream of the register file and drives that file's write port (wen/waddr/wdata).
- It accepts one retiring instruction per cycle from the LSU over a valid/ready handshake and holds it in a one-entry pipeline register. It forms the final result, including load byte/half extraction and sign extension.
- It commits the instruction, counts retired instructions, and halts the core on ebreak.

Parameters:
- XLEN, 32, data width of results and register-file write data
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clock  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  LSU presents a retiring instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  32  PC of the instruction
- in_rd  in  5  destination register index
- in_wen  in  1  instruction writes rd
- in_is_load  in  1  result comes from memory data
- in_funct3  in  3  load size/sign encoding
- in_addr_lo  in  2  load address bits [1:0]
- in_alu_result  in  XLEN  non-load result
- in_mem_rdata  in  XLEN  raw 32-bit aligned memory word
- in_ebreak  in  1  instruction is ebreak
- commit_stall  in  1  hold commit (debug/difftest back-pressure)
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  32  PC of retiring instruction
- halted  out  1  core halted by ebreak
- instret  out  CNT_W  retired-instruction count

Behaviour:
- State machine has three states:
  - EMPTY: no entry held.
  - FULL: one entry held.
  - HALTED: terminal until reset.
- Reset:
  - State goes to EMPTY and instret clears to 0.
  - Every output is 0: rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, halted.
  - Any entry held at the reset edge is dropped without commit.
- Handshake:
  - Accept occurs when in_valid && in_ready at the posedge.
  - in_ready = (state==EMPTY) || (state==FULL && !commit_stall && !entry_ebreak).
  - in_ready is 0 in HALTED.
  - in_valid is ignored when in_ready=0; the LSU holds its payload stable until accepted.
- Capture: the result is computed at accept and stored registered, so rf_wdata comes straight from a flop.
  - If in_is_load=0: result = in_alu_result.
  - If in_is_load=1, with byte = in_mem_rdata[8*in_addr_lo +: 8] and half = in_mem_rdata[16*in_addr_lo[1] +: 16]:
    - funct3 000: sign-extend byte.
    - funct3 100: zero-extend byte.
    - funct3 001: sign-extend half.
    - funct3 101: zero-extend half.
    - funct3 010 and all other codes: full word.
  - Misalignment is not checked here; the LSU owns that check.
  - The stored entry holds pc, rd, wen, result and ebreak.
- Commit fires in the cycle where state==FULL && !commit_stall:
  - commit_valid=1 and commit_pc=entry pc.
  - rf_wen = entry_wen && (entry_rd != 0); rf_waddr=entry rd; rf_wdata=entry result.
  - instret increments by 1 at that posedge, wrapping modulo 2^CNT_W.
  - Outside commit cycles, rf_wen=0 and commit_valid=0. rf_waddr and rf_wdata keep the entry values and are don't-care.
- Latency and throughput:
  - An instruction accepted at edge N is written into the register file at edge N+1 when commit_stall=0.
  - Accept and commit in the same cycle are allowed, giving 1 instruction/cycle sustained.
  - In FULL, commit with no new accept goes to EMPTY; commit with a new accept stays FULL holding the new entry.
- commit_stall=1 in FULL:
  - The entry is held, with no rf write, no commit_valid and no instret change.
  - in_ready=0 while the stall holds.
- ebreak:
  - The ebreak commits normally: a pulse, an instret increment, and an rf write only if wen and rd≠0.
  - The state then goes to HALTED at that edge; no new accept is taken alongside it.
  - In HALTED: halted=1, in_ready=0, rf_wen=0, commit_valid=0. instret is frozen.
  - Only reset leaves HALTED.
- Reset asserted on the same edge as an accept or commit: reset wins; nothing is captured or counted.

Test Plan:
- Back-to-back ALU ops with rd=1,2,3 and results 0x11,0x22,0x33, commit_stall=0:
  - in_ready stays 1.
  - rf_wen is high for 3 consecutive cycles with waddr 1,2,3 and wdata 0x11,0x22,0x33.
  - instret=3.
- Load with mem_rdata=0x80FF7F01:
  - lb with addr_lo=3 → 0xFFFFFF80.
  - lbu with addr_lo=1 → 0x0000007F.
  - lh with addr_lo=2 → 0xFFFF80FF.
  - lhu with addr_lo=0 → 0x00007F01.
  - lw → 0x80FF7F01.
- rd=0 with wen=1 and alu_result 0xDEAD → commit_valid=1, rf_wen=0, instret increments.
- commit_stall high for 3 cycles with an entry held and a new in_valid pending:
  - in_ready=0, rf_wen=0 and instret unchanged for those 3 cycles.
  - After release, the held entry commits, then the pending one commits next cycle, in order.
- ebreak at pc 0x80000010 followed by a valid ALU op:
  - commit_pc=0x80000010 with commit_valid=1.
  - halted=1 from the next cycle; the following op is never accepted; instret frozen.
- reset pulsed while FULL and while HALTED → all outputs 0, instret=0, in_ready=1 the cycle after reset deasserts.
